dmem_arbiter: RTL

Two-port arbiter and sequencer in front of the single-port 256-word data memory. It arbitrates between port 0 (CPU load/store path) and port 1 (debug/DMA loader) with round-robin priority. It drives the memory's addr/write_data/mem_read/mem_write strobes for exactly one cycle per granted access and returns registered read data with a one-cycle ack pulse. Out-of-range addresses are trapped here, so the memory never sees them.

---
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports, the data-memory bus and the busy flag
// for dmem_arbiter; slave is the arbiter side, master is the environment side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_read;
    logic              mem_write;

    logic              busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_read_data,
        output p0_ack, p0_rdata, p0_err,
        output p1_ack, p1_rdata, p1_err,
        output mem_addr, mem_write_data, mem_read, mem_write,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_read_data,
        input  p0_ack, p0_rdata, p0_err,
        input  p1_ack, p1_rdata, p1_err,
        input  mem_addr, mem_write_data, mem_read, mem_write,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single-port data memory.
// One granted access takes IDLE -> ACCESS -> DONE; out-of-range addresses never reach memory.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

    state_t            r_state;
    logic              r_last_grant;
    logic              r_port;
    logic              r_we;
    logic              r_oor;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_busy;
    logic              r_p0_ack;
    logic              r_p0_err;
    logic [DATA_W-1:0] r_p0_rdata;
    logic              r_p1_ack;
    logic              r_p1_err;
    logic [DATA_W-1:0] r_p1_rdata;

    logic              w_any_req;
    logic              w_winner;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_in_range;

    assign w_any_req = bus.p0_req | bus.p1_req;

    // On a tie the port that did not win last time is served.
    always_comb begin
        w_winner = 1'b0;
        if (bus.p0_req && bus.p1_req) begin
            w_winner = ~r_last_grant;
        end else if (bus.p1_req) begin
            w_winner = 1'b1;
        end
    end

    assign w_sel_we       = w_winner ? bus.p1_we    : bus.p0_we;
    assign w_sel_addr     = w_winner ? bus.p1_addr  : bus.p0_addr;
    assign w_sel_wdata    = w_winner ? bus.p1_wdata : bus.p0_wdata;
    assign w_sel_in_range = (w_sel_addr < DEPTH_LIM);

    // NOTE: every output is a flop, so the memory strobes are loaded on the
    // IDLE->ACCESS edge to be high for exactly the ACCESS cycle; all state uses <=.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_oor        <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_busy       <= 1'b0;
            r_p0_ack     <= 1'b0;
            r_p0_err     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_ack     <= 1'b0;
            r_p1_err     <= 1'b0;
            r_p1_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_port       <= w_winner;
                        r_last_grant <= w_winner;
                        r_we         <= w_sel_we;
                        r_oor        <= ~w_sel_in_range;
                        r_busy       <= 1'b1;
                        r_state      <= S_ACCESS;
                        // Out-of-range requests leave the memory bus untouched.
                        if (w_sel_in_range) begin
                            r_mem_addr  <= w_sel_addr;
                            r_mem_wdata <= w_sel_wdata;
                            r_mem_write <= w_sel_we;
                            r_mem_read  <= ~w_sel_we;
                        end
                    end
                end

                S_ACCESS: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    if (r_port == 1'b0) begin
                        r_p0_ack <= 1'b1;
                        r_p0_err <= r_oor;
                        if (r_oor) begin
                            r_p0_rdata <= '0;
                        end else if (!r_we) begin
                            r_p0_rdata <= bus.mem_read_data;
                        end
                    end else begin
                        r_p1_ack <= 1'b1;
                        r_p1_err <= r_oor;
                        if (r_oor) begin
                            r_p1_rdata <= '0;
                        end else if (!r_we) begin
                            r_p1_rdata <= bus.mem_read_data;
                        end
                    end
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    r_p0_ack <= 1'b0;
                    r_p0_err <= 1'b0;
                    r_p1_ack <= 1'b0;
                    r_p1_err <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_p0_ack    <= 1'b0;
                    r_p0_err    <= 1'b0;
                    r_p1_ack    <= 1'b0;
                    r_p1_err    <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.p0_ack         = r_p0_ack;
    assign bus.p0_err         = r_p0_err;
    assign bus.p0_rdata       = r_p0_rdata;
    assign bus.p1_ack         = r_p1_ack;
    assign bus.p1_err         = r_p1_err;
    assign bus.p1_rdata       = r_p1_rdata;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_write_data = r_mem_wdata;
    assign bus.mem_read       = r_mem_read;
    assign bus.mem_write      = r_mem_write;
    assign bus.busy           = r_busy;

endmodule
